alu_mem_pipe: RTL and testbench
===============================

// Module: alu_mem_pipe
// PURPOSE
//   Parametrised, handshaked ALU -> address register -> data memory -> output register path.
//   Executes one ALU-only, load or store operation per transaction, with valid/ready flow control.
//   Owns its data memory. Sits between the stack-processor control unit and the operand registers.
//   Memory out-of-range address bits wrap.
// PARAMETERS
//   WIDTH  16  datapath width: operands, ALU result, memory word
//   AW     10  memory address width; depth = 2**AW words, address = alu_result[AW-1:0]
// PORTS
//   CLK        in   1      clock, all state updates on rising edge
//   reset      in   1      asynchronous, active-high; clears all state except memory contents
//   in_valid   in   1      request valid
//   in_ready   out  1      block can accept a request
//   mode       in   2      00 ALU-only, 01 LOAD, 10 STORE, 11 treated as ALU-only
//   alu_op     in   2      00 add, 01 sub (a-imm), 10 and, 11 or
//   a_val      in   WIDTH  ALU operand A / base address
//   b_val      in   WIDTH  store data
//   imm        in   WIDTH  sign-extended immediate, ALU operand B
//   out_valid  out  1      result/flags valid, held until accepted
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  ALU: ALU result; LOAD: memory word; STORE: ALU result (address)
//   zero       out  1      ALU result == 0
//   ovflw      out  1      signed overflow of add/sub; 0 for and/or
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; ovflw=0;
//     internal aluout/rdata/operand regs=0. Memory contents unchanged.
//   Reset mid-operation aborts the transaction; a STORE not yet past MEM does not write.
//   FSM: IDLE, EXEC, MEM, WB, DONE.
//   in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//   On accept edge: mode, alu_op, a_val, b_val, imm latched; state -> EXEC.
//     Inputs are ignored at all other times.
//   EXEC edge: aluout <= ALU(a,imm) truncated to WIDTH; zero/ovflw latched.
//     ALU-only: result<=ALU value and state -> DONE; otherwise state -> MEM.
//   MEM edge: memory addressed by aluout[AW-1:0].
//     STORE: mem[addr]<=b; state -> DONE.
//     LOAD: rdata<=mem[addr] (synchronous read); state -> WB.
//   WB edge: result<=rdata; state -> DONE.
//   DONE: out_valid=1. result/zero/ovflw are stable until out_ready.
//     out_ready & !in_valid -> IDLE.
//     out_ready & in_valid -> accept the new request in the same edge and go to EXEC (back-to-back).
//   Latency from accept edge to out_valid rising: ALU 2 edges, STORE 3, LOAD 4.
//   Throughput with out_ready=1 and back-to-back requests: one op per 2/3/4 cycles respectively.
//   Overflow: add -> a,imm same sign and result sign differs; sub -> a,imm differ and result sign != a sign.
//   Read-after-write: a LOAD issued after a STORE to the same address returns the stored data
//     (store completes before the load reaches MEM).
//   mode 11 behaves identically to 00.
// TESTING
//   reset high mid-LOAD (state MEM) -> next cycle out_valid=0, in_ready=1, result=0, zero=0, ovflw=0
//   ALU add a=16'h7FFF imm=1, out_ready=1 -> out_valid 2 edges after accept, result=16'h8000, ovflw=1, zero=0
//   STORE a=16'h0100 imm=16'h0005 b=16'hBEEF, then LOAD a=16'h0105 imm=0
//     -> STORE result=16'h0105 (out_valid at 3 edges);
//     -> LOAD result=16'hBEEF (out_valid 4 edges after its accept)
//   AW=10: STORE to addr 16'h0403 data 16'h1234, LOAD addr 16'h0003 -> 16'h1234 (wrap)
//   sub a=5 imm=5 with out_ready=0 for 3 cycles -> out_valid held, result=0, zero=1, in_ready=0;
//     then out_ready=1 with in_valid=1 -> new request accepted in the same cycle
//   STORE in MEM with reset asserted before the edge, then LOAD same addr -> old contents returned

Source files
------------

// File: rtl/alu_mem_pipe.sv
// alu_mem_pipe
//   Handshaked ALU -> address register -> data memory -> output register path.
//   Each accepted request runs one ALU-only, LOAD or STORE operation through
//   the IDLE/EXEC/MEM/WB/DONE sequence. The block owns its data memory.
//   Memory address bits above AW are dropped, so addresses wrap.
// Ports
//   CLK        in   rising-edge clock
//   reset      in   asynchronous active-high reset (memory contents kept)
//   in_valid   in   request valid
//   in_ready   out  request can be accepted this cycle
//   mode       in   00/11 ALU-only, 01 LOAD, 10 STORE
//   alu_op     in   00 add, 01 sub (a-imm), 10 and, 11 or
//   a_val      in   ALU operand A / base address
//   b_val      in   store data
//   imm        in   sign-extended immediate, ALU operand B
//   out_valid  out  result/flags valid, held until out_ready
//   out_ready  in   consumer accepts result
//   result     out  ALU value, loaded word, or store address
//   zero       out  ALU result was zero
//   ovflw      out  signed overflow of add/sub
module alu_mem_pipe #(
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovflw
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXEC = 3'd1;
  localparam logic [2:0] MEM  = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_STORE = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [2:0]       state_r;
  logic [1:0]       mode_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] imm_r;
  logic [WIDTH-1:0] aluout_r;
  logic [WIDTH-1:0] rdata_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             ovflw_r;

  logic [WIDTH-1:0] mem_r [0:(1<<AW)-1];

  logic [WIDTH-1:0] alu_s;
  logic             ovf_s;
  logic             accept_s;
  logic             is_mem_s;
  logic             is_store_s;
  logic             mem_we_s;
  logic [AW-1:0]    addr_s;

  // Handshake and decode of the latched request.
  always_comb begin
    in_ready   = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    accept_s   = in_valid && in_ready;
    is_store_s = (mode_r == MODE_STORE);
    is_mem_s   = (mode_r == MODE_LOAD) || is_store_s;
    addr_s     = aluout_r[AW-1:0];
    // Reset forces state_r away from MEM asynchronously, so an aborted
    // store never reaches the write edge.
    mem_we_s   = (state_r == MEM) && is_store_s;
  end

  // ALU and signed-overflow detection on the latched operands.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    ovf_s = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_s = a_r + imm_r;
        ovf_s = (a_r[WIDTH-1] == imm_r[WIDTH-1]) && (alu_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        alu_s = a_r - imm_r;
        ovf_s = (a_r[WIDTH-1] != imm_r[WIDTH-1]) && (alu_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND: begin
        alu_s = a_r & imm_r;
        ovf_s = 1'b0;
      end
      OP_OR: begin
        alu_s = a_r | imm_r;
        ovf_s = 1'b0;
      end
      default: begin
        alu_s = {WIDTH{1'b0}};
        ovf_s = 1'b0;
      end
    endcase
  end

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[addr_s] <= b_r;
    end
  end

  // Request latch, sequencing FSM, and output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      mode_r   <= 2'b00;
      op_r     <= 2'b00;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      imm_r    <= {WIDTH{1'b0}};
      aluout_r <= {WIDTH{1'b0}};
      rdata_r  <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      ovflw_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        mode_r <= mode;
        op_r   <= alu_op;
        a_r    <= a_val;
        b_r    <= b_val;
        imm_r  <= imm;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          aluout_r <= alu_s;
          zero_r   <= (alu_s == {WIDTH{1'b0}});
          ovflw_r  <= ovf_s;
          if (is_mem_s) begin
            state_r <= MEM;
          end else begin
            result_r <= alu_s;
            state_r  <= DONE;
          end
        end
        MEM: begin
          if (is_store_s) begin
            result_r <= aluout_r;
            state_r  <= DONE;
          end else begin
            rdata_r <= mem_r[addr_s];
            state_r <= WB;
          end
        end
        WB: begin
          result_r <= rdata_r;
          state_r  <= DONE;
        end
        DONE: begin
          // Back-to-back: a new request is accepted on the same edge
          // that retires the current result.
          if (accept_s) begin
            state_r <= EXEC;
          end else if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid = (state_r == DONE);
    result    = result_r;
    zero      = zero_r;
    ovflw     = ovflw_r;
  end

endmodule

// File: tb/tb_alu_mem_pipe.sv
// Directed bench for alu_mem_pipe: hand-computed vectors, immediate assertions.
module tb_alu_mem_pipe;

  logic        CLK = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [1:0]  alu_op;
  logic [15:0] a_val;
  logic [15:0] b_val;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        ovflw;

  int checks = 0;
  int errors = 0;

  alu_mem_pipe #(.WIDTH(16), .AW(10)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .alu_op(alu_op), .a_val(a_val), .b_val(b_val), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovflw(ovflw)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for in_ready, and take the accept edge.
  task automatic issue(input logic [1:0] m, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] i);
    int n;
    mode = m; alu_op = op; a_val = a; b_val = b; imm = i;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    chk("in_ready_wait", {15'd0, in_ready}, 16'd1);
    tick;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid rises.
  task automatic wait_out(input string tag, input int lat);
    int n;
    n = 1;
    while (!out_valid && n < 12) begin
      tick;
      n++;
    end
    chk(tag, n[15:0], lat[15:0]);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; alu_op = 2'b00; a_val = 16'h0000; b_val = 16'h0000; imm = 16'h0000;
    tick; tick;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_result", result, 16'h0000);
    chk("rst_zero", {15'd0, zero}, 16'd0);
    chk("rst_ovflw", {15'd0, ovflw}, 16'd0);
    reset = 1'b0;
    tick;

    // add with signed overflow
    issue(2'b00, 2'b00, 16'h7FFF, 16'h0000, 16'h0001);
    wait_out("add_latency", 2);
    chk("add_result", result, 16'h8000);
    chk("add_ovflw", {15'd0, ovflw}, 16'd1);
    chk("add_zero", {15'd0, zero}, 16'd0);
    tick;

    // mode 11 behaves as ALU-only; and giving zero
    issue(2'b11, 2'b10, 16'hF0F0, 16'h0000, 16'h0F0F);
    wait_out("and_latency", 2);
    chk("and_result", result, 16'h0000);
    chk("and_zero", {15'd0, zero}, 16'd1);
    chk("and_ovflw", {15'd0, ovflw}, 16'd0);
    tick;

    issue(2'b00, 2'b11, 16'h1200, 16'h0000, 16'h0034);
    wait_out("or_latency", 2);
    chk("or_result", result, 16'h1234);
    tick;

    // STORE then LOAD to same address
    issue(2'b10, 2'b00, 16'h0100, 16'hBEEF, 16'h0005);
    wait_out("store_latency", 3);
    chk("store_result", result, 16'h0105);
    tick;
    issue(2'b01, 2'b00, 16'h0105, 16'h0000, 16'h0000);
    wait_out("load_latency", 4);
    chk("load_result", result, 16'hBEEF);
    chk("load_zero", {15'd0, zero}, 16'd0);
    tick;

    // negative immediate forms the same address
    issue(2'b01, 2'b00, 16'h0107, 16'h0000, 16'hFFFE);
    wait_out("load_negimm_latency", 4);
    chk("load_negimm_result", result, 16'hBEEF);
    chk("load_negimm_ovflw", {15'd0, ovflw}, 16'd0);
    tick;

    // address wrap with AW=10
    issue(2'b10, 2'b00, 16'h0400, 16'h1234, 16'h0003);
    wait_out("wrap_store_latency", 3);
    chk("wrap_store_result", result, 16'h0403);
    tick;
    issue(2'b01, 2'b00, 16'h0003, 16'h0000, 16'h0000);
    wait_out("wrap_load_latency", 4);
    chk("wrap_load_result", result, 16'h1234);
    tick;

    // sub with signed overflow
    issue(2'b00, 2'b01, 16'h8000, 16'h0000, 16'h0001);
    wait_out("sub_ovf_latency", 2);
    chk("sub_ovf_result", result, 16'h7FFF);
    chk("sub_ovf_ovflw", {15'd0, ovflw}, 16'd1);
    tick;

    // reset while LOAD is in MEM
    issue(2'b01, 2'b00, 16'h0105, 16'h0000, 16'h0000);
    tick;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("midrst_result", result, 16'h0000);
    chk("midrst_zero", {15'd0, zero}, 16'd0);
    chk("midrst_ovflw", {15'd0, ovflw}, 16'd0);
    tick;
    reset = 1'b0;
    tick;

    // sub to zero, result held under backpressure, then back-to-back accept
    out_ready = 1'b0;
    issue(2'b00, 2'b01, 16'h0005, 16'h0000, 16'h0005);
    wait_out("hold_latency", 2);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("hold_out_valid", {15'd0, out_valid}, 16'd1);
      chk("hold_in_ready", {15'd0, in_ready}, 16'd0);
      chk("hold_result", result, 16'h0000);
      chk("hold_zero", {15'd0, zero}, 16'd1);
    end
    out_ready = 1'b1;
    mode = 2'b00; alu_op = 2'b00; a_val = 16'h0001; imm = 16'h0002; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", {15'd0, in_ready}, 16'd1);
    tick;
    in_valid = 1'b0;
    chk("b2b_out_valid_drop", {15'd0, out_valid}, 16'd0);
    wait_out("b2b_latency", 2);
    chk("b2b_result", result, 16'h0003);
    chk("b2b_zero", {15'd0, zero}, 16'd0);
    tick;

    // aborted STORE must not write
    issue(2'b10, 2'b00, 16'h0200, 16'hAAAA, 16'h0000);
    wait_out("abort_pre_latency", 3);
    tick;
    issue(2'b10, 2'b00, 16'h0200, 16'h5555, 16'h0000);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    issue(2'b01, 2'b00, 16'h0200, 16'h0000, 16'h0000);
    wait_out("abort_load_latency", 4);
    chk("abort_load_result", result, 16'hAAAA);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
